reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 4, register address width; register count NREG = 2**ADDR_W.
REQ-003 The module SHALL have parameter PC_REG, default 15, index whose reads return R15.
REQ-004 The module SHALL have parameter LINK_REG, default 14, index written by LINK.
REQ-005 The module SHALL have parameter PC_OFFSET, default 4, constant subtracted from R15 for link writes.
REQ-006 The module SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous active-high reset
A1  input  ADDR_W  read port 1 address
A2  input  ADDR_W  read port 2 address
A3  input  ADDR_W  write address
WD3  input  DATA_W  write data
WE3  input  1  write enable
R15  input  DATA_W  current PC value
LINK  input  1  write R15-PC_OFFSET to LINK_REG
SET_BUSY  input  1  mark BUSY_ADDR pending (multi-cycle load issued)
BUSY_ADDR  input  ADDR_W  register to mark pending
RD1  output  DATA_W  read data port 1
RD2  output  DATA_W  read data port 2
BUSY1  output  1  RD1 operand not yet valid
BUSY2  output  1  RD2 operand not yet valid
STALL  output  1  BUSY1 | BUSY2
PEND_CNT  output  ADDR_W+1  number of registers currently pending

Function
REQ-007 The block SHALL hold NREG-1 storage words (all indices except PC_REG) and an NREG-bit busy vector.
REQ-008 Reads SHALL be combinational, priority: Ax==PC_REG -> R15; LINK && Ax==LINK_REG -> R15-PC_OFFSET; WE3 && A3==Ax -> WD3 (write-through bypass); else stored word.
REQ-009 On a rising CLK edge with WE3=1 and A3!=PC_REG, storage[A3] SHALL take WD3; WE3 with A3==PC_REG SHALL be discarded.
REQ-010 On a rising CLK edge with LINK=1, storage[LINK_REG] SHALL take (R15-PC_OFFSET) mod 2**DATA_W; LINK SHALL win over WE3 when A3==LINK_REG.
REQ-011 Busy update per edge, in order: clear busy[A3] if WE3; clear busy[LINK_REG] if LINK; set busy[BUSY_ADDR] if SET_BUSY; same-edge set and clear of one index SHALL leave it set.
REQ-012 SET_BUSY with BUSY_ADDR==PC_REG SHALL be ignored; busy[PC_REG] SHALL remain 0.
REQ-013 BUSY1 SHALL equal busy[A1] and not (WE3 && A3==A1) and not (LINK && A1==LINK_REG); BUSY2 likewise for A2.
REQ-014 STALL SHALL be combinational BUSY1 | BUSY2.
REQ-015 PEND_CNT SHALL be a registered counter equal to the population count of the busy vector after each edge (incremented on a 0->1 transition, decremented on 1->0, unchanged when both or neither occur on distinct indices net); it SHALL never exceed NREG-1.
REQ-016 Write latency SHALL be one edge: a value written at edge N is returned by the stored path from edge N onward and by bypass in the cycle before.

Reset
REQ-017 RST=1 SHALL asynchronously clear all storage words, the busy vector and PEND_CNT to 0, independent of CLK.
REQ-018 While RST=1, writes, LINK and SET_BUSY SHALL have no effect; outputs SHALL follow REQ-008/013 from the cleared state (RD=0 except PC_REG/bypass paths, BUSY1=BUSY2=STALL=0).
REQ-019 RST asserted mid-pending-load SHALL drop all pending marks; no later write is required to clear them.

Verification
REQ-020 Reset then A1=3,A2=15,R15=0x100 -> RD1=0, RD2=0x100, STALL=0, PEND_CNT=0.
REQ-021 WE3=1,A3=5,WD3=0xDEADBEEF,A1=5 same cycle -> RD1=0xDEADBEEF before edge; after edge with WE3=0 RD1 still 0xDEADBEEF.
REQ-022 WE3=1,A3=14,WD3=0x55,LINK=1,R15=0x200 at one edge -> reg14=0x1FC; write to A3=15 -> no storage change, RD of 15 returns R15.
REQ-023 SET_BUSY on 2 and 7 over two edges -> PEND_CNT=2, A1=2 gives BUSY1=1,STALL=1; WE3 A3=2 same cycle -> BUSY1=0; after edge PEND_CNT=1.
REQ-024 Same edge SET_BUSY addr 7 and WE3 A3=7 with reg7 pending -> reg7 updated, busy[7] stays 1, PEND_CNT unchanged.
REQ-025 RST pulsed between clock edges with 3 registers pending and nonzero data -> immediately PEND_CNT=0, STALL=0, all stored reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with R15-as-PC read path, link writes, write-through bypass and
// a per-register pending (scoreboard) vector for multi-cycle loads.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_REG    = 15,
  parameter int LINK_REG  = 14,
  parameter int PC_OFFSET = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] R15,
  input  logic              LINK,
  input  logic              SET_BUSY,
  input  logic [ADDR_W-1:0] BUSY_ADDR,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              STALL,
  output logic [ADDR_W:0]   PEND_CNT
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  // The PC_REG slot exists in the array but is never written, so it stays at
  // zero and synthesis trims it; reads of that index are served from R15.
  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [DATA_W-1:0] link_val;

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              bz [2];

  assign link_val = R15 - DATA_W'(PC_OFFSET);

  assign ra[0] = A1;
  assign ra[1] = A2;
  assign RD1   = rd[0];
  assign RD2   = rd[1];
  assign BUSY1 = bz[0];
  assign BUSY2 = bz[1];
  assign STALL = bz[0] | bz[1];

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latches are inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (ra[p] == PC_IDX)
        rd[p] = R15;
      else if (LINK && ra[p] == LINK_IDX)
        rd[p] = link_val;
      else if (WE3 && A3 == ra[p])
        rd[p] = WD3;
      else
        rd[p] = mem[ra[p]];
      // An operand being produced this cycle is already valid via the bypass.
      bz[p] = busy[ra[p]] && !(WE3 && A3 == ra[p]) && !(LINK && ra[p] == LINK_IDX);
    end
  end

  // Clears apply before the set, so a same-edge set and clear leaves the mark.
  always_comb begin
    busy_nxt = busy;
    if (WE3)
      busy_nxt[A3] = 1'b0;
    if (LINK)
      busy_nxt[LINK_IDX] = 1'b0;
    if (SET_BUSY && BUSY_ADDR != PC_IDX)
      busy_nxt[BUSY_ADDR] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[i]);
  end

  // NOTE: storage is reset word-by-word because reads after reset must be 0;
  // this forces flops rather than a RAM macro, which is acceptable at this size.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else begin
      if (WE3 && A3 != PC_IDX)
        mem[A3] <= WD3;
      // Later non-blocking assignment wins: LINK overrides a WE3 to LINK_REG.
      if (LINK)
        mem[LINK_IDX] <= link_val;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy     <= '0;
      PEND_CNT <= '0;
    end else begin
      busy     <= busy_nxt;
      PEND_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb: one vector per clock cycle,
// outputs compared before the edge, plus hand-written reset and saturation runs.
module tb_reg_file_sb;

  logic        CLK;
  logic        RST;
  logic [3:0]  A1, A2, A3, BUSY_ADDR;
  logic [31:0] WD3, R15, RD1, RD2;
  logic        WE3, LINK, SET_BUSY, BUSY1, BUSY2, STALL;
  logic [4:0]  PEND_CNT;

  int total = 0;
  int bad   = 0;

  reg_file_sb dut (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
    .R15(R15), .LINK(LINK), .SET_BUSY(SET_BUSY), .BUSY_ADDR(BUSY_ADDR),
    .RD1(RD1), .RD2(RD2), .BUSY1(BUSY1), .BUSY2(BUSY2), .STALL(STALL),
    .PEND_CNT(PEND_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  a1, a2, a3, ba;
    logic [31:0] wd3, r15;
    logic        we3, link, sb;
    logic [31:0] rd1, rd2;
    logic        b1, b2, st;
    logic [4:0]  pend;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input int a1, input int a2, input int a3,
                              input logic [31:0] wd3, input int we3,
                              input logic [31:0] r15, input int link,
                              input int sb, input int ba,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input int b1, input int b2, input int st,
                              input int pend);
    vec_t v;
    v.a1 = 4'(a1); v.a2 = 4'(a2); v.a3 = 4'(a3); v.ba = 4'(ba);
    v.wd3 = wd3; v.r15 = r15;
    v.we3 = 1'(we3); v.link = 1'(link); v.sb = 1'(sb);
    v.rd1 = rd1; v.rd2 = rd2;
    v.b1 = 1'(b1); v.b2 = 1'(b2); v.st = 1'(st);
    v.pend = 5'(pend);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    A3 = 0; WD3 = 0; WE3 = 0; LINK = 0; SET_BUSY = 0; BUSY_ADDR = 0; R15 = 32'h100;
  endtask

  initial begin
    //               a1 a2 a3 wd3         we r15          lk sb ba  rd1           rd2          b1 b2 st pend
    vecs[0]  = mk( 5, 3, 5, 32'hDEADBEEF, 1, 32'h100, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
    vecs[1]  = mk( 5, 6, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
    vecs[2]  = mk(14,15,14, 32'h55,       1, 32'h200, 1, 0, 0, 32'h1FC,      32'h200,      0, 0, 0, 0);
    vecs[3]  = mk(15,14,15, 32'h1234,     1, 32'h300, 0, 0, 0, 32'h300,      32'h1FC,      0, 0, 0, 0);
    vecs[4]  = mk(15,14, 0, 32'h0,        0, 32'h304, 0, 0, 0, 32'h304,      32'h1FC,      0, 0, 0, 0);
    vecs[5]  = mk( 2, 7, 0, 32'h0,        0, 32'h100, 0, 1, 2, 32'h0,        32'h0,        0, 0, 0, 0);
    vecs[6]  = mk( 2, 7, 0, 32'h0,        0, 32'h100, 0, 1, 7, 32'h0,        32'h0,        1, 0, 1, 1);
    vecs[7]  = mk( 2, 7, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 2);
    vecs[8]  = mk( 2, 3, 2, 32'hA5A5,     1, 32'h100, 0, 0, 0, 32'hA5A5,     32'h0,        0, 0, 0, 2);
    vecs[9]  = mk( 2, 7, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'hA5A5,     32'h0,        0, 1, 1, 1);
    vecs[10] = mk( 7, 2, 7, 32'h77,       1, 32'h100, 0, 1, 7, 32'h77,       32'hA5A5,     0, 0, 0, 1);
    vecs[11] = mk( 7, 2, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'h77,       32'hA5A5,     1, 0, 1, 1);
    vecs[12] = mk(15, 7, 0, 32'h0,        0, 32'h400, 0, 1,15, 32'h400,      32'h77,       0, 1, 1, 1);
    vecs[13] = mk(14,15, 0, 32'h0,        0, 32'h500, 1, 1,14, 32'h4FC,      32'h500,      0, 0, 0, 1);
    vecs[14] = mk(14,15, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'h4FC,      32'h100,      1, 0, 1, 2);
    vecs[15] = mk(14, 7, 0, 32'h0,        0, 32'h3,   1, 0, 0, 32'hFFFFFFFF, 32'h77,       0, 1, 1, 2);
    vecs[16] = mk(14, 7, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'hFFFFFFFF, 32'h77,       0, 1, 1, 1);
    vecs[17] = mk( 3, 5, 0, 32'h0,        0, 32'h100, 0, 1, 3, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1);
    vecs[18] = mk( 9, 3, 0, 32'h0,        0, 32'h100, 0, 1, 9, 32'h0,        32'h0,        0, 1, 1, 2);

    RST = 1'b1; A1 = 0; A2 = 0;
    idle();
    repeat (2) @(negedge CLK);

    // Outputs while held in reset.
    A1 = 3; A2 = 15; R15 = 32'h100;
    #1;
    check("rst rd1", RD1, 32'h0);
    check("rst rd2", RD2, 32'h100);
    check("rst stall", 32'(STALL), 32'h0);
    check("rst pend", 32'(PEND_CNT), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      A1 = vecs[i].a1; A2 = vecs[i].a2; A3 = vecs[i].a3; WD3 = vecs[i].wd3;
      WE3 = vecs[i].we3; R15 = vecs[i].r15; LINK = vecs[i].link;
      SET_BUSY = vecs[i].sb; BUSY_ADDR = vecs[i].ba;
      #1;
      check($sformatf("v%0d rd1", i), RD1, vecs[i].rd1);
      check($sformatf("v%0d rd2", i), RD2, vecs[i].rd2);
      check($sformatf("v%0d busy1", i), 32'(BUSY1), 32'(vecs[i].b1));
      check($sformatf("v%0d busy2", i), 32'(BUSY2), 32'(vecs[i].b2));
      check($sformatf("v%0d stall", i), 32'(STALL), 32'(vecs[i].st));
      check($sformatf("v%0d pend", i), 32'(PEND_CNT), 32'(vecs[i].pend));
    end

    // Asynchronous reset between edges with registers 3, 7, 9 pending.
    @(negedge CLK);
    idle();
    A1 = 5; A2 = 7;
    #1;
    check("pre-rst pend", 32'(PEND_CNT), 32'd3);
    check("pre-rst stall", 32'(STALL), 32'h1);
    check("pre-rst rd1", RD1, 32'hDEADBEEF);
    #1 RST = 1'b1;
    #1;
    check("async pend", 32'(PEND_CNT), 32'h0);
    check("async stall", 32'(STALL), 32'h0);
    check("async rd1", RD1, 32'h0);
    check("async rd2", RD2, 32'h0);

    // Writes, LINK and SET_BUSY across an edge while reset is held.
    WE3 = 1; A3 = 6; WD3 = 32'h66; SET_BUSY = 1; BUSY_ADDR = 4; LINK = 1;
    @(posedge CLK);
    @(negedge CLK);
    idle();
    for (int a = 0; a < 15; a++) begin
      A1 = 4'(a);
      #1;
      check($sformatf("rst clear r%0d", a), RD1, 32'h0);
    end
    RST = 1'b0;
    @(negedge CLK);
    A1 = 4; A2 = 6;
    #1;
    check("post-rst busy1", 32'(BUSY1), 32'h0);
    check("post-rst rd2", RD2, 32'h0);
    check("post-rst pend", 32'(PEND_CNT), 32'h0);

    // Mark every index pending; the PC index is refused so the count tops out at 15.
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK);
      SET_BUSY = 1; BUSY_ADDR = 4'(a);
    end
    @(negedge CLK);
    idle();
    A1 = 15; A2 = 0;
    #1;
    check("sat pend", 32'(PEND_CNT), 32'd15);
    check("sat pc busy", 32'(BUSY1), 32'h0);
    check("sat r0 busy", 32'(BUSY2), 32'h1);
    WE3 = 1; A3 = 0; WD3 = 32'h1;
    @(negedge CLK);
    idle();
    #1;
    check("clear pend", 32'(PEND_CNT), 32'd14);
    check("clear r0 busy", 32'(BUSY2), 32'h0);
    check("clear r0 data", RD2, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
